// File: rtl/vx_dot8_arbiter_if.sv
// vx_dot8_arbiter_if: requester, dot8-unit and result handshake bundle; master = arbiter side, slave = environment side
interface vx_dot8_arbiter_if #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_LANES    = 4,
  parameter int TAG_WIDTH    = 16,
  parameter int MAX_INFLIGHT = 8
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  logic [NUM_REQS-1:0]                      req_valid;
  logic [NUM_REQS-1:0][NUM_LANES*64-1:0]    req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       req_tag;
  logic [NUM_REQS-1:0]                      req_ready;
  logic                                     unit_valid;
  logic [NUM_LANES*64-1:0]                  unit_data;
  logic [TAG_WIDTH-1:0]                     unit_tag;
  logic                                     unit_ready;
  logic                                     unit_rsp_valid;
  logic [NUM_LANES*32-1:0]                  unit_rsp_data;
  logic [TAG_WIDTH-1:0]                     unit_rsp_tag;
  logic                                     unit_rsp_ready;
  logic [NUM_REQS-1:0]                      rsp_valid;
  logic [NUM_LANES*32-1:0]                  rsp_data;
  logic [TAG_WIDTH-1:0]                     rsp_tag;
  logic [NUM_REQS-1:0]                      rsp_ready;
  logic [CW-1:0]                            inflight;
  modport master (
    input  req_valid, req_data, req_tag, unit_ready, unit_rsp_valid, unit_rsp_data, unit_rsp_tag, rsp_ready,
    output req_ready, unit_valid, unit_data, unit_tag, unit_rsp_ready, rsp_valid, rsp_data, rsp_tag, inflight
  );
  modport slave (
    output req_valid, req_data, req_tag, unit_ready, unit_rsp_valid, unit_rsp_data, unit_rsp_tag, rsp_ready,
    input  req_ready, unit_valid, unit_data, unit_tag, unit_rsp_ready, rsp_valid, rsp_data, rsp_tag, inflight
  );
endinterface

// File: rtl/vx_dot8_arbiter.sv
// vx_dot8_arbiter: round-robin share of one in-order dot8 unit among NUM_REQS requesters, results steered back via an ownership FIFO; ports clk, reset, bus (master: req/unit/rsp handshakes, inflight)
module vx_dot8_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_LANES    = 4,
  parameter int TAG_WIDTH    = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input logic               clk,
  input logic               reset,
  vx_dot8_arbiter_if.master bus
);
  localparam int IW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  logic [IW-1:0] rr_ptr, lock_idx, scan_g, g, h, idx;
  logic [IW:0]   sum;
  logic          locked, found, any, full, empty, issue, pop;
  logic [IW-1:0] fifo [MAX_INFLIGHT];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_comb begin
    scan_g = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      idx = IW'(sum >= (IW+1)'(NUM_REQS) ? sum - (IW+1)'(NUM_REQS) : sum);
      if (bus.req_valid[idx]) begin
        scan_g = idx;
        found = 1'b1;
      end
    end
  end
  // a stalled offer stays pinned to its requester until the unit takes it
  assign g     = locked ? lock_idx : scan_g;
  assign any   = locked ? bus.req_valid[lock_idx] : found;
  // full/empty come from the registered count, so a same-cycle retire never frees a slot early
  assign full  = bus.inflight == CW'(MAX_INFLIGHT);
  assign empty = bus.inflight == '0;
  assign bus.unit_valid = !reset && any && !full;
  assign issue          = bus.unit_valid && bus.unit_ready;
  assign bus.req_ready  = issue ? NUM_REQS'(1) << g : '0;
  assign bus.unit_data  = bus.req_data[g];
  assign bus.unit_tag   = bus.req_tag[g];
  assign h                  = fifo[rd_ptr];
  assign bus.rsp_valid      = (bus.unit_rsp_valid && !empty) ? NUM_REQS'(1) << h : '0;
  assign bus.unit_rsp_ready = !empty && bus.rsp_ready[h];
  assign bus.rsp_data       = bus.unit_rsp_data;
  assign bus.rsp_tag        = bus.unit_rsp_tag;
  assign pop                = bus.unit_rsp_valid && bus.unit_rsp_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      locked       <= 1'b0;
      lock_idx     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.inflight <= '0;
    end else begin
      if (bus.unit_valid) begin
        locked   <= !bus.unit_ready;
        lock_idx <= g;
      end
      if (issue) begin
        fifo[wr_ptr] <= g;
        wr_ptr       <= wr_ptr + 1'b1;
        rr_ptr       <= g == IW'(NUM_REQS - 1) ? '0 : g + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (issue != pop) bus.inflight <= issue ? bus.inflight + 1'b1 : bus.inflight - 1'b1;
    end
  end
  a_rsp_without_owner: assert property (@(posedge clk) disable iff (reset) !(bus.unit_rsp_valid && empty))
    else $error("unit response with no outstanding owner");
  a_locked_drop: assert property (@(posedge clk) disable iff (reset) locked |-> bus.req_valid[lock_idx])
    else $error("locked requester dropped req_valid");
endmodule

// File: tb/tb_vx_dot8_arbiter.sv
// tb_vx_dot8_arbiter: randomized requesters and unit model checked against a queue-based reference of the arbiter
module tb_vx_dot8_arbiter;
  localparam int N = 4, L = 4, TW = 16, MI = 8, LAT = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vx_dot8_arbiter_if #(.NUM_REQS(N), .NUM_LANES(L), .TAG_WIDTH(TW), .MAX_INFLIGHT(MI)) bus ();
  vx_dot8_arbiter #(.NUM_REQS(N), .NUM_LANES(L), .TAG_WIDTH(TW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {
    logic [L*32-1:0] d;
    logic [TW-1:0]   t;
    int              due;
  } ent_t;
  int n_chk = 0, n_fail = 0;
  ent_t uq[$];
  int own[$];
  int rr = 0, lk_i = 0, seq = 0, cyc = 0;
  bit lk = 0, hold = 0;
  int p_req = 0, p_ur = 100, p_rr = 100;
  bit rv[N];
  logic [L*64-1:0] rd[N];
  logic [TW-1:0] rt[N];
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [L*32-1:0] dot8(input logic [L*64-1:0] d);
    logic [L*32-1:0] r;
    int s;
    r = '0;
    for (int l = 0; l < L; l++) begin
      s = 0;
      for (int b = 0; b < 4; b++)
        s += int'($signed(d[l*64+b*8+:8])) * int'($signed(d[l*64+32+b*8+:8]));
      r[l*32+:32] = s;
    end
    return r;
  endfunction
  task automatic step(input bit rst_now);
    int g, h;
    bit any, uv, ur, urv, urr;
    ent_t e;
    for (int i = 0; i < N; i++)
      if (!rv[i] && $urandom_range(99) < p_req) begin
        rv[i] = 1'b1;
        for (int w = 0; w < L*2; w++) rd[i][w*32+:32] = $urandom;
        rt[i] = TW'({seq[11:0], 4'(i)});
        seq++;
      end
    @(negedge clk);
    reset = rst_now;
    if (rst_now) uq.delete();
    ur  = $urandom_range(99) < p_ur;
    urv = !hold && uq.size() > 0 && uq[0].due <= cyc;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = rv[i];
      bus.req_data[i]  = rd[i];
      bus.req_tag[i]   = rt[i];
      bus.rsp_ready[i] = $urandom_range(99) < p_rr;
    end
    bus.unit_ready     = ur;
    bus.unit_rsp_valid = urv;
    bus.unit_rsp_data  = urv ? uq[0].d : '0;
    bus.unit_rsp_tag   = urv ? uq[0].t : '0;
    #1;
    any = 0;
    g = 0;
    if (lk) begin
      g = lk_i;
      any = rv[g];
    end else
      for (int k = 0; k < N && !any; k++)
        if (rv[(rr + k) % N]) begin
          g = (rr + k) % N;
          any = 1;
        end
    uv = !rst_now && any && own.size() < MI;
    check("unit_valid", bus.unit_valid, uv);
    check("req_ready", bus.req_ready, (uv && ur) ? (1 << g) : 0);
    if (uv) begin
      check("unit_data", bus.unit_data, rd[g]);
      check("unit_tag", bus.unit_tag, rt[g]);
    end
    urr = 0;
    if (!rst_now) begin
      h = own.size() > 0 ? own[0] : 0;
      urr = own.size() > 0 && bus.rsp_ready[h];
      check("rsp_valid", bus.rsp_valid, (urv && own.size() > 0) ? (1 << h) : 0);
      check("unit_rsp_ready", bus.unit_rsp_ready, urr);
      check("inflight", bus.inflight, own.size());
      if (urv) begin
        check("rsp_data", bus.rsp_data, uq[0].d);
        check("rsp_tag", bus.rsp_tag, uq[0].t);
      end
    end
    if (rst_now) begin
      rr = 0;
      lk = 0;
      own.delete();
    end else begin
      if (urv && urr) begin
        void'(own.pop_front());
        void'(uq.pop_front());
      end
      if (uv && ur) begin
        own.push_back(g);
        e.d = dot8(rd[g]);
        e.t = rt[g];
        e.due = cyc + LAT;
        uq.push_back(e);
        rr = (g + 1) % N;
        lk = 0;
        rv[g] = 0;
      end else if (uv) begin
        lk = 1;
        lk_i = g;
      end
    end
    cyc++;
    @(posedge clk);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_tag = '0;
    bus.rsp_ready = '0;
    bus.unit_ready = 1'b0;
    bus.unit_rsp_valid = 1'b0;
    bus.unit_rsp_data = '0;
    bus.unit_rsp_tag = '0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 0;
      rd[i] = '0;
      rt[i] = '0;
    end
    repeat (2) step(1'b1);
    step(1'b0);
    rv[2] = 1;
    for (int w = 0; w < L*2; w++) rd[2][w*32+:32] = $urandom;
    rt[2] = 16'hA002;
    repeat (8) step(1'b0);
    p_req = 100; p_ur = 100; p_rr = 100;
    repeat (40) step(1'b0);
    p_req = 70; p_ur = 80; p_rr = 80;
    repeat (300) step(1'b0);
    p_req = 60; p_ur = 25;
    repeat (200) step(1'b0);
    p_req = 80; p_ur = 90; p_rr = 20;
    repeat (200) step(1'b0);
    hold = 1; p_req = 100; p_ur = 100; p_rr = 100;
    repeat (20) step(1'b0);
    hold = 0;
    repeat (100) step(1'b0);
    hold = 1;
    for (int i = 0; i < 50 && own.size() < 5; i++) step(1'b0);
    #1 check("fill_before_reset", bus.inflight >= 5, 1'b1);
    step(1'b1);
    hold = 0;
    for (int i = 0; i < N; i++) rv[i] = 1;
    repeat (200) step(1'b0);
    p_req = 0; p_ur = 100; p_rr = 100;
    repeat (60) step(1'b0);
    #1 check("drained", bus.inflight, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
